enc_speed_sampler: RTL and testbench

- Downstream consumer of the quadrature position counter's 32-bit output (position count left-shifted by 7).
- Samples position at a fixed period, forms a signed per-period delta, and saturates it to a 16-bit speed word.
- Presents the result to the MCU-side register interface with a valid/ack handshake.
- Provides the wheel-speed measurement used by the motor control loop.

---
 rtl/enc_speed_sampler_if.sv | 18 +
 rtl/enc_speed_sampler.sv | 199 +++++++++++++++++++
 tb/tb_enc_speed_sampler.sv | 340 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/enc_speed_sampler_if.sv
// enc_speed_sampler_if
// Speed result handshake between the sampler and the MCU-side register block.
//   spd_out   : signed speed word, counts per sample period
//   spd_valid : a new, not yet acknowledged sample is present
//   spd_ack   : one-cycle acknowledge from the consumer
// Modports:
//   master : the sampler (drives spd_out/spd_valid, receives spd_ack)
//   slave  : the consumer (reads spd_out/spd_valid, drives spd_ack)
interface enc_speed_sampler_if #(
    parameter int OUT_W = 16
);
    logic [OUT_W-1:0] spd_out;
    logic             spd_valid;
    logic             spd_ack;

    modport master (output spd_out, output spd_valid, input spd_ack);
    modport slave  (input spd_out, input spd_valid, output spd_ack);
endinterface

// File: rtl/enc_speed_sampler.sv
// enc_speed_sampler
// Samples the quadrature position word once per PERIOD clocks, forms the signed
// per-period delta (wrap-safe modulo 2^P), saturates it to OUT_W bits and
// presents it to the MCU through a valid/ack handshake.
// Ports:
//   clk        : system clock
//   rst        : synchronous, active-high reset
//   pos_in     : position word from the encoder counter (count << SHIFT)
//   en         : sampling enable; dropping it returns the sampler to IDLE
//   clr        : synchronous clear of spd_valid, ovf and sample_cnt
//   spd_if     : master side of the speed handshake (spd_out/spd_valid/spd_ack)
//   ovf        : sticky, an unacknowledged sample was overwritten
//   sample_cnt : number of samples produced, wrapping at 16 bits
// Build option:
//   SPD_AVG4_EN : when defined, the output is the floor-average of the last four
//                 raw deltas instead of the raw delta itself.
module enc_speed_sampler #(
    parameter int PERIOD = 50000,
    parameter int SHIFT  = 7,
    parameter int OUT_W  = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [31:0]         pos_in,
    input  logic                en,
    input  logic                clr,
    enc_speed_sampler_if.master spd_if,
    output logic                ovf,
    output logic [15:0]         sample_cnt
);
    localparam int P  = 32 - SHIFT;
    localparam int TW = 16;
    localparam logic [TW-1:0] TIMER_LAST = TW'(PERIOD - 1);
    localparam logic signed [P+1:0] SAT_MAX = (P+2)'(2 ** (OUT_W - 1) - 1);
    localparam logic signed [P+1:0] SAT_MIN = ~SAT_MAX;

    typedef enum logic [1:0] {IDLE, PRIME, RUN} state_t;

    state_t           state_q, state_d;
    logic [TW-1:0]    timer_q, timer_d;
    logic [P-1:0]     prev_q, prev_d;
    logic [OUT_W-1:0] spd_out_q, spd_out_d;
    logic             spd_valid_q, spd_valid_d;
    logic             ovf_q, ovf_d;
    logic [15:0]      sample_cnt_q, sample_cnt_d;

    logic [P-1:0]        cur;
    logic [P-1:0]        delta;
    logic                tick;
    logic signed [P+1:0] sat_in;
    logic                unused_low_bits;

    function automatic logic signed [P+1:0] sext(input logic [P-1:0] v);
        return {{2{v[P-1]}}, v};
    endfunction

    function automatic logic [OUT_W-1:0] sat(input logic signed [P+1:0] v);
        logic [OUT_W-1:0] r;
        if (v > SAT_MAX) begin
            r = {1'b0, {(OUT_W-1){1'b1}}};
        end else if (v < SAT_MIN) begin
            r = {1'b1, {(OUT_W-1){1'b0}}};
        end else begin
            r = v[OUT_W-1:0];
        end
        return r;
    endfunction

    assign cur             = pos_in[31:SHIFT];
    assign unused_low_bits = ^pos_in[SHIFT-1:0];
    // Modulo-2^P subtraction keeps the delta correct across counter wrap.
    assign delta           = cur - prev_q;

`ifdef SPD_AVG4_EN
    // The current delta is the fourth history entry, so only the three
    // previous deltas need storage. Entry 0 is the most recent one.
    logic [2:0][P-1:0]   hist_q, hist_d;
    logic signed [P+1:0] hist_sum;

    always_comb begin
        hist_d   = hist_q;
        hist_sum = sext(delta) + sext(hist_q[0]) + sext(hist_q[1]) + sext(hist_q[2]);
        if (!en) begin
            hist_d = '0;
        end else if (tick) begin
            hist_d[0] = delta;
            hist_d[1] = hist_q[0];
            hist_d[2] = hist_q[1];
        end
    end

    // Arithmetic shift floors toward minus infinity.
    assign sat_in = hist_sum >>> 2;

    always_ff @(posedge clk) begin
        if (rst) begin
            hist_q <= '0;
        end else begin
            hist_q <= hist_d;
        end
    end
`else
    assign sat_in = sext(delta);
`endif

    // Sampling FSM and handshake. PRIME throws away the first, partial
    // interval after enable so every reported delta spans a full period.
    always_comb begin
        state_d      = state_q;
        timer_d      = timer_q;
        prev_d       = prev_q;
        spd_out_d    = spd_out_q;
        spd_valid_d  = spd_valid_q;
        ovf_d        = ovf_q;
        sample_cnt_d = sample_cnt_q;
        tick         = 1'b0;

        if (!en) begin
            state_d = IDLE;
            timer_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    prev_d  = cur;
                    timer_d = '0;
                    state_d = PRIME;
                end
                PRIME: begin
                    if (timer_q == TIMER_LAST) begin
                        prev_d  = cur;
                        timer_d = '0;
                        state_d = RUN;
                    end else begin
                        timer_d = timer_q + 1'b1;
                    end
                end
                RUN: begin
                    if (timer_q == TIMER_LAST) begin
                        tick    = 1'b1;
                        prev_d  = cur;
                        timer_d = '0;
                    end else begin
                        timer_d = timer_q + 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                    timer_d = '0;
                end
            endcase
        end

        // A new sample beats a simultaneous ack; only an unacked overwrite
        // counts as overflow.
        if (tick) begin
            spd_out_d    = sat(sat_in);
            spd_valid_d  = 1'b1;
            sample_cnt_d = sample_cnt_q + 1'b1;
            if (spd_valid_q && !spd_if.spd_ack) begin
                ovf_d = 1'b1;
            end
        end else if (spd_if.spd_ack) begin
            spd_valid_d = 1'b0;
        end

        // clr still lets a coincident sample land in spd_out.
        if (clr) begin
            spd_valid_d  = 1'b0;
            ovf_d        = 1'b0;
            sample_cnt_d = '0;
        end
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            timer_q      <= '0;
            prev_q       <= '0;
            spd_out_q    <= '0;
            spd_valid_q  <= 1'b0;
            ovf_q        <= 1'b0;
            sample_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            prev_q       <= prev_d;
            spd_out_q    <= spd_out_d;
            spd_valid_q  <= spd_valid_d;
            ovf_q        <= ovf_d;
            sample_cnt_q <= sample_cnt_d;
        end
    end

    assign spd_if.spd_out   = spd_out_q;
    assign spd_if.spd_valid = spd_valid_q;
    assign ovf              = ovf_q;
    assign sample_cnt       = sample_cnt_q;
endmodule

// File: tb/tb_enc_speed_sampler.sv
// tb_enc_speed_sampler
// Self-checking bench for enc_speed_sampler with PERIOD=10, SHIFT=7.
// A behavioural model (edge counting since enable, integer deltas, a queue of
// recent deltas for the averaging build) predicts every output on every cycle;
// table vectors and short hand-written sequences add fixed expected values.
// Build option SPD_AVG4_EN selects the averaging expectations.
module tb_enc_speed_sampler;
    localparam int PERIOD = 10;

    logic        clk;
    logic        rst;
    logic        en;
    logic        clr;
    logic [31:0] pos_in;
    logic        ovf;
    logic [15:0] sample_cnt;

    enc_speed_sampler_if #(.OUT_W(16)) spd_if();

    enc_speed_sampler #(
        .PERIOD(PERIOD),
        .SHIFT (7),
        .OUT_W (16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .pos_in    (pos_in),
        .en        (en),
        .clr       (clr),
        .spd_if    (spd_if.master),
        .ovf       (ovf),
        .sample_cnt(sample_cnt)
    );

    typedef struct {
        int startCount;
        int step;
        int rawDelta;
        int expOut;
    } vec_t;

    vec_t vecs[5];

    int checks = 0;
    int errors = 0;
    int posStep = 0;
    int stepPeriod = 1;
    int cycCount = 0;

    // Reference model state
    int   mK;
    logic [24:0] mPrev;
    int   mOut;
    bit   mValid;
    bit   mOvf;
    int   mCnt;
    int   mHist[$];

    // Free-running clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Safety net in case a wait is ever left unbounded
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    function automatic int satTb(input int v);
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    function automatic int floorDiv4(input int a);
        int q;
        q = a / 4;
        if ((a % 4 != 0) && (a < 0)) q = q - 1;
        return q;
    endfunction

    function automatic int expectedAt(input int v, input int t);
`ifdef SPD_AVG4_EN
        return satTb(floorDiv4(((t < 4) ? t : 4) * vecs[v].rawDelta));
`else
        return (t > 0) ? vecs[v].expOut : 0;
`endif
    endfunction

    task automatic checkVal(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic rstI, input logic enI, input logic ackI, input logic clrI);
        rst = rstI;
        en = enI;
        spd_if.spd_ack = ackI;
        clr = clrI;
    endtask

    // Advance the model by what the DUT does on this clock edge.
    task automatic modelEdge();
        logic [24:0] curM;
        int d;
        int sum;
        int o;
        bit tick;
        curM = pos_in[31:7];
        tick = 0;
        o = 0;
        d = 0;
        if (rst) begin
            mK = 0;
            mPrev = '0;
            mOut = 0;
            mValid = 0;
            mOvf = 0;
            mCnt = 0;
            mHist.delete();
            return;
        end
        if (!en) begin
            mK = 0;
            mHist.delete();
        end else begin
            mK++;
            if (mK == 1 || mK == PERIOD + 1) begin
                mPrev = curM;
            end else if (mK > PERIOD + 1 && (mK - 1) % PERIOD == 0) begin
                d = int'(curM) - int'(mPrev);
                if (d >= (1 << 24)) d = d - (1 << 25);
                else if (d < -(1 << 24)) d = d + (1 << 25);
                mPrev = curM;
                tick = 1;
            end
        end
        if (tick) begin
`ifdef SPD_AVG4_EN
            mHist.push_back(d);
            if (mHist.size() > 4) void'(mHist.pop_front());
            sum = 0;
            foreach (mHist[i]) sum += mHist[i];
            o = satTb(floorDiv4(sum));
`else
            sum = d;
            o = satTb(sum);
`endif
            if (mValid && !spd_if.spd_ack) mOvf = 1;
            mValid = 1;
            mOut = o;
            mCnt = (mCnt + 1) % 65536;
        end else if (spd_if.spd_ack) begin
            mValid = 0;
        end
        if (clr) begin
            mValid = 0;
            mOvf = 0;
            mCnt = 0;
        end
    endtask

    task automatic checkOutput();
        checkVal("model.spd_out", int'($signed(spd_if.spd_out)), mOut);
        checkVal("model.spd_valid", int'(spd_if.spd_valid), int'(mValid));
        checkVal("model.ovf", int'(ovf), int'(mOvf));
        checkVal("model.sample_cnt", int'(sample_cnt), mCnt);
    endtask

    // One clock: model the edge, compare on the falling edge, step position.
    task automatic cycle();
        @(posedge clk);
        modelEdge();
        @(negedge clk);
        checkOutput();
        cycCount++;
        if (cycCount % stepPeriod == 0) pos_in = pos_in + 32'(posStep * 128);
    endtask

    task automatic waitValid(input int maxCyc, output int n);
        n = 0;
        while (n < maxCyc) begin
            cycle();
            n++;
            if (spd_if.spd_valid) return;
        end
        n = -1;
    endtask

    task automatic doReset();
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        posStep = 0;
        stepPeriod = 1;
        cycle();
        cycle();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkVal("reset.spd_out", int'($signed(spd_if.spd_out)), 0);
        checkVal("reset.spd_valid", int'(spd_if.spd_valid), 0);
        checkVal("reset.ovf", int'(ovf), 0);
        checkVal("reset.sample_cnt", int'(sample_cnt), 0);
    endtask

    initial begin
        int n;
        vecs[0] = '{startCount: 0, step: 1,     rawDelta: 10,     expOut: 10};
        vecs[1] = '{startCount: 5, step: 0,     rawDelta: 0,      expOut: 0};
        vecs[2] = '{startCount: 2, step: -3,    rawDelta: -30,    expOut: -30};
        vecs[3] = '{startCount: 0, step: 4000,  rawDelta: 40000,  expOut: 32767};
        vecs[4] = '{startCount: 0, step: -4000, rawDelta: -40000, expOut: -32768};

        pos_in = '0;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        mK = 0; mPrev = '0; mOut = 0; mValid = 0; mOvf = 0; mCnt = 0;

        // Table vectors: latency, per-tick value, ack clearing, tick spacing
        for (int v = 0; v < 5; v++) begin
            doReset();
            pos_in = 32'(vecs[v].startCount) << 7;
            posStep = vecs[v].step;
            en = 1'b1;
            waitValid(40, n);
            checkVal($sformatf("v%0d.latency", v), n, 21);
            checkVal($sformatf("v%0d.cnt", v), int'(sample_cnt), 1);
            for (int t = 1; t <= 5; t++) begin
                checkVal($sformatf("v%0d.tick%0d.spd", v, t), int'($signed(spd_if.spd_out)), expectedAt(v, t));
                spd_if.spd_ack = 1'b1;
                cycle();
                spd_if.spd_ack = 1'b0;
                checkVal($sformatf("v%0d.tick%0d.ackClears", v, t), int'(spd_if.spd_valid), 0);
                if (t < 5) begin
                    waitValid(20, n);
                    checkVal($sformatf("v%0d.tick%0d.spacing", v, t), n, PERIOD - 1);
                end
            end
        end

        // Overwrite without ack sets ovf; clr then clears everything
        doReset();
        pos_in = '0;
        posStep = 1;
        en = 1'b1;
        waitValid(40, n);
        checkVal("ovf.latency", n, 21);
        repeat (PERIOD) cycle();
        checkVal("ovf.set", int'(ovf), 1);
        checkVal("ovf.valid", int'(spd_if.spd_valid), 1);
        checkVal("ovf.cnt", int'(sample_cnt), 2);
        checkVal("ovf.newest", int'($signed(spd_if.spd_out)), expectedAt(0, 2));
        clr = 1'b1;
        cycle();
        clr = 1'b0;
        checkVal("clr.ovf", int'(ovf), 0);
        checkVal("clr.valid", int'(spd_if.spd_valid), 0);
        checkVal("clr.cnt", int'(sample_cnt), 0);

        // Ack coincident with a tick, then clr coincident with a tick
        doReset();
        pos_in = '0;
        posStep = 1;
        en = 1'b1;
        waitValid(40, n);
        repeat (PERIOD - 1) cycle();
        spd_if.spd_ack = 1'b1;
        cycle();
        spd_if.spd_ack = 1'b0;
        checkVal("ackTick.ovf", int'(ovf), 0);
        checkVal("ackTick.valid", int'(spd_if.spd_valid), 1);
        checkVal("ackTick.cnt", int'(sample_cnt), 2);
        repeat (PERIOD - 1) cycle();
        clr = 1'b1;
        cycle();
        clr = 1'b0;
        checkVal("clrTick.valid", int'(spd_if.spd_valid), 0);
        checkVal("clrTick.cnt", int'(sample_cnt), 0);
        checkVal("clrTick.spd", int'($signed(spd_if.spd_out)), expectedAt(0, 3));

        // Reset mid-period needs a fresh prime
        repeat (5) cycle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        checkVal("rstMid.spd", int'($signed(spd_if.spd_out)), 0);
        checkVal("rstMid.valid", int'(spd_if.spd_valid), 0);
        checkVal("rstMid.cnt", int'(sample_cnt), 0);
        waitValid(40, n);
        checkVal("rstMid.latency", n, 21);

        // Delta of 8 per period, then en low/high restarts the history
        doReset();
        pos_in = '0;
        posStep = 8;
        stepPeriod = 10;
        en = 1'b1;
        waitValid(40, n);
        checkVal("hist.latency", n, 21);
        for (int t = 1; t <= 4; t++) begin
`ifdef SPD_AVG4_EN
            checkVal($sformatf("hist.tick%0d", t), int'($signed(spd_if.spd_out)), 2 * t);
`else
            checkVal($sformatf("hist.tick%0d", t), int'($signed(spd_if.spd_out)), 8);
`endif
            spd_if.spd_ack = 1'b1;
            cycle();
            spd_if.spd_ack = 1'b0;
            if (t < 4) waitValid(20, n);
        end
        en = 1'b0;
        cycle();
        en = 1'b1;
        waitValid(40, n);
        checkVal("hist.reenLatency", n, 21);
`ifdef SPD_AVG4_EN
        checkVal("hist.reenFirst", int'($signed(spd_if.spd_out)), 2);
`else
        checkVal("hist.reenFirst", int'($signed(spd_if.spd_out)), 8);
`endif

        // Randomized traffic against the model
        doReset();
        pos_in = $urandom;
        posStep = 0;
        stepPeriod = 1;
        en = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            cycle();
            if ($urandom_range(0, 49) == 0) posStep = int'($urandom_range(0, 8000)) - 4000;
            applyStimulus($urandom_range(0, 499) == 0,
                          $urandom_range(0, 99) >= 2,
                          $urandom_range(0, 4) == 0,
                          $urandom_range(0, 59) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
